// File: rtl/unidade_controle_multiciclo_if.sv
// Control-bundle interface between the multicycle MIPS control FSM and its datapath.
// Latency: none (wires only).
// Backpressure: mem_ready from memory stalls the FSM in its memory-access states.
//
// Ports carried: OP/Funct/Zero/mem_ready (datapath -> control) and all datapath
// control strobes plus the estado debug bus (control -> datapath).
// master = control unit side, slave = datapath/memory side.
interface unidade_controle_multiciclo_if;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;

    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       Ulasrca;
    logic [1:0] Ulasrcb;
    logic [2:0] ULA_Control;
    logic [1:0] PCSrc;
    logic       pc_en;
    logic       illegal_op;
    logic       instr_done;
    logic [3:0] estado;

    modport master (
        input  OP, Funct, Zero, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               Ulasrca, Ulasrcb, ULA_Control, PCSrc, pc_en,
               illegal_op, instr_done, estado
    );

    modport slave (
        output OP, Funct, Zero, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               Ulasrca, Ulasrcb, ULA_Control, PCSrc, pc_en,
               illegal_op, instr_done, estado
    );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS control FSM (add/sub/and/or/slt, lw, sw, beq, addi, j) sharing one memory port.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles with mem_ready held high.
// Backpressure: FETCH, MEMRD and MEMWR hold (one extra cycle per mem_ready=0) when MEM_HANDSHAKE=1.
//
// Ports: clk, rst (async, active-high); bus (master modport) carries OP/Funct/Zero/mem_ready
// in and IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Ulasrca, Ulasrcb,
// ULA_Control, PCSrc, pc_en, illegal_op, instr_done, estado out.
module unidade_controle_multiciclo #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    unidade_controle_multiciclo_if.master bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_SLT = 3'b111;

    logic [3:0] estado_q;
    logic [3:0] estado_d;
    logic       mem_ok;

    // Funct decode, shared by EXEC output and next-state logic.
    logic [2:0] funct_ula;
    logic       funct_ok;

    // Raw (pre-reset-gating) outputs.
    logic       iord_c, memwrite_c, irwrite_c, regdst_c, memtoreg_c, regwrite_c;
    logic       ulasrca_c;
    logic [1:0] ulasrcb_c, pcsrc_c;
    logic [2:0] ula_c;
    logic       pcwrite_c, branch_c, illegal_c, done_c;

    assign mem_ok = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_comb begin
        funct_ula = ULA_ADD;
        funct_ok  = 1'b1;
        case (bus.Funct)
            6'b100000: funct_ula = ULA_ADD;
            6'b100010: funct_ula = ULA_SUB;
            6'b100100: funct_ula = ULA_AND;
            6'b100101: funct_ula = ULA_OR;
            6'b101010: funct_ula = ULA_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado_q <= S_FETCH;
        else     estado_q <= estado_d;
    end

    always_comb begin
        estado_d = S_FETCH;
        case (estado_q)
            S_FETCH:  estado_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.OP)
                    OP_LW, OP_SW: estado_d = S_MEMADR;
                    OP_RTYPE:     estado_d = S_EXEC;
                    OP_BEQ:       estado_d = S_BRANCH;
                    OP_ADDI:      estado_d = S_ADDIEX;
                    OP_J:         estado_d = S_JUMP;
                    default:      estado_d = S_FETCH;
                endcase
            end
            S_MEMADR: estado_d = (bus.OP == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  estado_d = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWB:  estado_d = S_FETCH;
            S_MEMWR:  estado_d = mem_ok ? S_FETCH : S_MEMWR;
            S_EXEC:   estado_d = funct_ok ? S_ALUWB : S_FETCH;
            S_ALUWB:  estado_d = S_FETCH;
            S_BRANCH: estado_d = S_FETCH;
            S_ADDIEX: estado_d = S_ADDIWB;
            S_ADDIWB: estado_d = S_FETCH;
            S_JUMP:   estado_d = S_FETCH;
            default:  estado_d = S_FETCH;
        endcase
    end

    // Moore decode from the state register; only the memory states look at mem_ready.
    always_comb begin
        iord_c     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        ulasrca_c  = 1'b0;
        ulasrcb_c  = 2'b00;
        ula_c      = ULA_ADD;
        pcsrc_c    = 2'b00;
        pcwrite_c  = 1'b0;
        branch_c   = 1'b0;
        illegal_c  = 1'b0;
        done_c     = 1'b0;
        case (estado_q)
            S_FETCH: begin
                ulasrcb_c = 2'b01;
                irwrite_c = mem_ok;
                pcwrite_c = mem_ok;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                ulasrcb_c = 2'b11;
                case (bus.OP)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_c = 1'b0;
                    default:                                       illegal_c = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ulasrca_c = 1'b1;
                ulasrcb_c = 2'b10;
            end
            S_MEMRD: begin
                iord_c = 1'b1;
            end
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
            end
            S_MEMWR: begin
                // Strobe stays up for the whole stall so memory sees a stable request.
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                done_c     = mem_ok;
            end
            S_EXEC: begin
                ulasrca_c = 1'b1;
                if (funct_ok) ula_c = funct_ula;
                illegal_c = ~funct_ok;
            end
            S_ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                done_c     = 1'b1;
            end
            S_BRANCH: begin
                ulasrca_c = 1'b1;
                ula_c     = ULA_SUB;
                pcsrc_c   = 2'b01;
                branch_c  = 1'b1;
                done_c    = 1'b1;
            end
            S_ADDIEX: begin
                ulasrca_c = 1'b1;
                ulasrcb_c = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                done_c     = 1'b1;
            end
            S_JUMP: begin
                pcsrc_c   = 2'b10;
                pcwrite_c = 1'b1;
                done_c    = 1'b1;
            end
            default: begin
                // Unused codes: all defaults, next state recovers to FETCH.
            end
        endcase
    end

    // Reset suppresses every enable and pulse combinationally, since FETCH
    // would otherwise raise IRWrite while rst is still high.
    assign bus.IorD        = iord_c;
    assign bus.MemWrite    = memwrite_c & ~rst;
    assign bus.IRWrite     = irwrite_c & ~rst;
    assign bus.RegDst      = regdst_c;
    assign bus.MemtoReg    = memtoreg_c;
    assign bus.RegWrite    = regwrite_c & ~rst;
    assign bus.Ulasrca     = ulasrca_c;
    assign bus.Ulasrcb     = ulasrcb_c;
    assign bus.ULA_Control = ula_c;
    assign bus.PCSrc       = pcsrc_c;
    assign bus.pc_en       = (pcwrite_c | (branch_c & bus.Zero)) & ~rst;
    assign bus.illegal_op  = illegal_c & ~rst;
    assign bus.instr_done  = done_c & ~rst;
    assign bus.estado      = estado_q;

endmodule
